// File: rtl/temporizer_ctrl.sv
// rtl/temporizer_ctrl.sv - countdown timer controller with debounced buttons, preset load and completion flag
module temporizer_ctrl #(
    parameter int CLK_HZ          = 50_000_000,
    parameter int DEBOUNCE_CYCLES = 500_000,
    parameter int MAX_SECONDS     = 5999
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_go,
    input  logic        btn_load,
    input  logic        btn_clr,
    input  logic [12:0] load_value,
    output logic [12:0] num,
    output logic [1:0]  state,
    output logic        done
);

    typedef enum logic [1:0] {
        FINALIZADO = 2'b00,
        DETENIDO   = 2'b01,
        CONTANDO   = 2'b10
    } state_t;

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam int PW = $clog2(CLK_HZ);
    localparam logic [CW-1:0] CNT_MAX   = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);
    localparam logic [12:0]   MAX_NUM   = 13'(MAX_SECONDS);

    // Button lanes: index 0 = go, 1 = load, 2 = clr
    logic [2:0]    raw;
    logic [2:0]    s1;
    logic [2:0]    s2;
    logic [2:0]    db;
    logic [2:0]    db_prev;
    logic [2:0]    press;
    logic [CW-1:0] cnt [3];

    state_t        st;
    logic [PW-1:0] presc;

    assign raw   = {btn_clr, btn_load, btn_go};
    assign press = db & ~db_prev;
    assign state = st;

    // Synchronise each button, accept a new level only after it has been stable long enough
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1      <= '0;
            s2      <= '0;
            db      <= '0;
            db_prev <= '0;
            for (int i = 0; i < 3; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            s1      <= raw;
            s2      <= s1;
            db_prev <= db;
            for (int i = 0; i < 3; i++) begin
                if (s2[i] != db[i]) begin
                    if (cnt[i] == CNT_MAX) begin
                        db[i]  <= s2[i];
                        cnt[i] <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + 1'b1;
                    end
                end else begin
                    cnt[i] <= '0;
                end
            end
        end
    end

    // Timer FSM: commands resolved clr > load > go > second tick, one event per cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st    <= DETENIDO;
            num   <= '0;
            presc <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (press[2]) begin
                num   <= '0;
                st    <= DETENIDO;
                presc <= '0;
            end else if (press[1]) begin
                num   <= (load_value > MAX_NUM) ? MAX_NUM : load_value;
                st    <= DETENIDO;
                presc <= '0;
            end else if (press[0]) begin
                // Pausing throws away the partial second so resume restarts a full second
                if (st == DETENIDO && num != 13'd0) begin
                    st    <= CONTANDO;
                    presc <= '0;
                end else if (st == CONTANDO) begin
                    st    <= DETENIDO;
                    presc <= '0;
                end
            end else if (st == CONTANDO) begin
                if (presc == PRESC_MAX) begin
                    presc <= '0;
                    if (num > 13'd1) begin
                        num <= num - 13'd1;
                    end else begin
                        num  <= '0;
                        st   <= FINALIZADO;
                        done <= 1'b1;
                    end
                end else begin
                    presc <= presc + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_temporizer_ctrl.sv
// tb/tb_temporizer_ctrl.sv - scoreboard bench for temporizer_ctrl
module tb_temporizer_ctrl;

    localparam logic [1:0] RUN  = 2'b10;
    localparam logic [1:0] STOP = 2'b01;
    localparam logic [1:0] FIN  = 2'b00;
    localparam logic [2:0] M_GO   = 3'b001;
    localparam logic [2:0] M_LOAD = 3'b010;
    localparam logic [2:0] M_CLR  = 3'b100;

    typedef struct packed {
        int          cyc;
        logic [12:0] num;
        logic [1:0]  st;
        logic        dn;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        btn_go, btn_load, btn_clr;
    logic [12:0] load_value;
    logic [12:0] num;
    logic [1:0]  state;
    logic        done;

    int    cyc = 0;
    int    n_checks = 0;
    int    n_fail = 0;
    int    done_cnt = 0;
    exp_t  sb[$];
    string sb_tag[$];

    temporizer_ctrl #(
        .CLK_HZ(10),
        .DEBOUNCE_CYCLES(4),
        .MAX_SECONDS(5999)
    ) dut (
        .clk(clk),
        .reset(rst),
        .btn_go(btn_go),
        .btn_load(btn_load),
        .btn_clr(btn_clr),
        .load_value(load_value),
        .num(num),
        .state(state),
        .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic push(input int c, input logic [12:0] n, input logic [1:0] s, input logic d, input string tag);
        exp_t x;
        x.cyc = c;
        x.num = n;
        x.st  = s;
        x.dn  = d;
        sb.push_back(x);
        sb_tag.push_back(tag);
    endtask

    task automatic press(input logic [2:0] m, input int hold);
        {btn_clr, btn_load, btn_go} = m;
        repeat (hold) @(negedge clk);
        {btn_clr, btn_load, btn_go} = 3'b000;
        repeat (8) @(negedge clk);
    endtask

    // Compare every expectation whose edge number has just been reached
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                check({sb_tag[i], ".num"},   32'(num),   32'(sb[i].num));
                check({sb_tag[i], ".state"}, 32'(state), 32'(sb[i].st));
                check({sb_tag[i], ".done"},  32'(done),  32'(sb[i].dn));
                sb.delete(i);
                sb_tag.delete(i);
            end
        end
    end

    initial begin
        int e;
        int t;
        rst = 1'b1;
        {btn_clr, btn_load, btn_go} = 3'b000;
        load_value = '0;
        repeat (3) @(negedge clk);
        check("rst.num", 32'(num), 0);
        check("rst.state", 32'(state), 32'(STOP));
        check("rst.done", 32'(done), 0);
        rst = 1'b0;
        @(negedge clk);

        // load held 10 cycles; load_value changes after acceptance, must not reload
        load_value = 13'd125;
        t = cyc;
        push(t + 6, 0, STOP, 0, "load_pre");
        push(t + 7, 125, STOP, 0, "load");
        push(t + 17, 125, STOP, 0, "load_once");
        btn_load = 1'b1;
        repeat (8) @(negedge clk);
        load_value = 13'd77;
        repeat (2) @(negedge clk);
        btn_load = 1'b0;
        repeat (8) @(negedge clk);

        // countdown 3 -> 0
        load_value = 13'd3;
        e = cyc + 7;
        push(e, 3, STOP, 0, "ld3");
        press(M_LOAD, 6);
        e = cyc + 7;
        push(e, 3, RUN, 0, "go_run");
        push(e + 9, 3, RUN, 0, "tick1_pre");
        push(e + 10, 2, RUN, 0, "tick1");
        push(e + 20, 1, RUN, 0, "tick2");
        push(e + 29, 1, RUN, 0, "tick3_pre");
        push(e + 30, 0, FIN, 1, "fin_done");
        push(e + 31, 0, FIN, 0, "done_drop");
        push(e + 40, 0, FIN, 0, "fin_hold");
        press(M_GO, 6);
        repeat (e + 41 - cyc) @(negedge clk);
        e = cyc + 7;
        push(e + 2, 0, FIN, 0, "go_in_fin");
        press(M_GO, 6);

        // pause and resume
        load_value = 13'd55;
        e = cyc + 7;
        push(e, 55, STOP, 0, "ld55");
        press(M_LOAD, 6);
        e = cyc + 7;
        push(e, 55, RUN, 0, "run55");
        press(M_GO, 6);
        repeat (e + 48 - cyc) @(negedge clk);
        push(e + 54, 50, RUN, 0, "pre_pause");
        push(e + 55, 50, STOP, 0, "pause");
        push(e + 155, 50, STOP, 0, "pause_hold");
        press(M_GO, 6);
        repeat (e + 156 - cyc) @(negedge clk);
        e = cyc + 7;
        push(e, 50, RUN, 0, "resume");
        push(e + 9, 50, RUN, 0, "resume_pre");
        push(e + 10, 49, RUN, 0, "resume_tick");
        press(M_GO, 6);
        repeat (e + 11 - cyc) @(negedge clk);

        // clamp, clear, go ignored at zero
        load_value = 13'd8000;
        e = cyc + 7;
        push(e, 5999, STOP, 0, "clamp");
        press(M_LOAD, 6);
        e = cyc + 7;
        push(e, 0, STOP, 0, "clr");
        press(M_CLR, 6);
        e = cyc + 7;
        push(e + 3, 0, STOP, 0, "go_zero");
        press(M_GO, 6);

        // glitch then simultaneous clr+load
        load_value = 13'd7;
        e = cyc + 7;
        push(e, 7, STOP, 0, "ld7");
        press(M_LOAD, 6);
        t = cyc;
        push(t + 10, 7, STOP, 0, "glitch");
        push(t + 14, 7, STOP, 0, "glitch_late");
        btn_go = 1'b1;
        repeat (3) @(negedge clk);
        btn_go = 1'b0;
        repeat (14) @(negedge clk);
        load_value = 13'd20;
        e = cyc + 7;
        push(e, 0, STOP, 0, "prio");
        push(e + 3, 0, STOP, 0, "prio_hold");
        press(M_CLR | M_LOAD, 6);

        // async reset while counting
        load_value = 13'd40;
        e = cyc + 7;
        push(e, 40, STOP, 0, "ld40");
        press(M_LOAD, 6);
        e = cyc + 7;
        push(e, 40, RUN, 0, "run40");
        push(e + 5, 40, RUN, 0, "cnt40");
        press(M_GO, 6);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("arst.num", 32'(num), 0);
        check("arst.state", 32'(state), 32'(STOP));
        check("arst.done", 32'(done), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        push(cyc + 20, 0, STOP, 0, "post_rst");
        repeat (25) @(negedge clk);

        check("sb_drain", 32'(sb.size()), 0);
        check("done_pulses", 32'(done_cnt), 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
